// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Purpose:
//   Generic pipeline stage register. It carries a control bundle and a data
//   bundle across a stage boundary using valid/ready handshakes. A 2-entry
//   skid buffer (main + skid) makes In_Ready a function of registered state
//   and Stall only, so downstream backpressure never reaches upstream through
//   combinational logic. The stage also supports stall hold, flush-to-bubble
//   and occupancy reporting. Optional saturating performance counters are
//   built when the macro PIPE_STAGE_PERF_CNT_EN is defined.
//
// Parameters:
//   DATA_W     payload width (default 416)
//   CTRL_W     control bundle width; all-zero control is a bubble/NOP
//   CLEAR_DATA 1: flush/vacate zeroes data registers, 0: data is held
//   CNT_W      width of the optional performance counters
//
// Ports:
//   Clock        rising-edge stage clock
//   Reset        synchronous, active-high reset
//   Flush        synchronous bubble insertion (priority over everything but Reset)
//   Stall        freezes both handshake sides this cycle
//   In_Valid     upstream entry valid
//   In_Ready     stage can take an entry (~skid_valid & ~Stall)
//   Ctrl_In      upstream control bundle
//   Data_In      upstream data bundle
//   Out_Valid    main entry is presented (main_valid & ~Stall)
//   Out_Ready    downstream accept
//   Ctrl_Out     main control bundle, forced to zero when main is empty
//   Data_Out     main data bundle
//   Occupancy    registered count of held entries (0/1/2)
//   Stall_Count  stalled cycles with a valid main entry (PIPE_STAGE_PERF_CNT_EN only)
//   Flush_Count  flushes that discarded a valid entry (PIPE_STAGE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int DATA_W     = 416,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              Stall,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [1:0]        Occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  Stall_Count,
    output logic [CNT_W-1:0]  Flush_Count
`endif
);

    // Bit 1 is skid_valid, bit 0 is main_valid; 2'b10 is never reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic main_valid;
    logic skid_valid;
    logic in_ready;
    logic out_valid;
    logic accept;
    logic emit;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // Handshakes depend only on registered state and Stall, so Stall forces
    // both accept and emit low and every register holds.
    assign in_ready  = ~skid_valid & ~Stall;
    assign out_valid = main_valid & ~Stall;
    assign accept    = In_Valid & in_ready;
    assign emit      = out_valid & Out_Ready;

    // Next-state and datapath steering. Flush wins over any handshake and
    // drops whatever was offered this cycle. Vacated slots always get their
    // control zeroed so a stale entry can never look like a real one; data is
    // only zeroed when CLEAR_DATA asks for it.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (Flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = Ctrl_In;
                        main_data_d = Data_In;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_ctrl_d = Ctrl_In;
                        main_data_d = Data_In;
                    end else if (accept) begin
                        skid_ctrl_d = Ctrl_In;
                        skid_data_d = Data_In;
                        state_d     = FULL;
                    end else if (emit) begin
                        main_ctrl_d = '0;
                        if (CLEAR_DATA) begin
                            main_data_d = '0;
                        end
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        if (CLEAR_DATA) begin
                            skid_data_d = '0;
                        end
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        occupancy_d = {1'b0, state_d[1]} + {1'b0, state_d[0]};
    end

    // State, payload and occupancy registers. Reset clears everything,
    // including data, regardless of CLEAR_DATA.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            occupancy_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign In_Ready  = in_ready;
    assign Out_Valid = out_valid;
    assign Ctrl_Out  = main_valid ? main_ctrl_q : '0;
    assign Data_Out  = main_data_q;
    assign Occupancy = occupancy_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] flush_count_q;
    logic             flush_discard;

    // A flush only counts when it actually throws something away: a held
    // entry or an entry being offered in the same cycle.
    assign flush_discard = Flush & (main_valid | skid_valid | In_Valid);

    // Saturating event counters; Flush does not clear them, only Reset does.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (Stall && main_valid && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_ONE;
            end
            if (flush_discard && (flush_count_q != CNT_MAX)) begin
                flush_count_q <= flush_count_q + CNT_ONE;
            end
        end
    end

    assign Stall_Count = stall_count_q;
    assign Flush_Count = flush_count_q;
`endif

endmodule
